uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period helper.
// Imported by the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_REC_BYTE,
    S_STOP,
    S_DATA
  } state_t;

  function automatic int cycle_of(
    input int clk_fre,
    input int baud_rate
  );
    return clk_fre * 1000000 / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-out handshake of the UART receiver toward its consumer.
// Carries the received byte, valid/ready and error pulses.
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       frame_err;
  logic       overrun_err;

  modport master (
    output rx_data,
    output rx_data_valid,
    output frame_err,
    output overrun_err,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  frame_err,
    input  overrun_err,
    output rx_data_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for rx_pin plus falling-edge detect.
// All flops reset high so reset release never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_pin,
  output logic rx_s,
  output logic fall
);

  logic s1;
  logic s2;
  logic rx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      s1   <= rx_pin;
      s2   <= s1;
      rx_d <= s2;
    end
  end

  assign rx_s = s2;
  assign fall = rx_d & ~s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte output,
// framing and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  uart_rx_if.master  bus
);

  localparam int CYCLE = cycle_of(CLK_FRE, BAUD_RATE);
  localparam int MID   = CYCLE / 2 - 1;
  // An overrun frame is skipped up to its stop-bit midpoint,
  // so its internal falling edges are never taken as starts.
  localparam int IGN   = 9 * CYCLE + MID;

  localparam logic [15:0] MID_C = 16'(MID);
  localparam logic [15:0] END_C = 16'(CYCLE - 1);
  localparam logic [15:0] IGN_C = 16'(IGN);

  if (CYCLE < 4) begin : g_cycle_chk
    $error("uart_rx: CYCLE must be >= 4");
  end

  logic        rx_s;
  logic        fall;
  state_t      state;
  logic [15:0] cycle_cnt;
  logic [15:0] ign_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        fe_q;
  logic        ov_q;
  logic        edge_ok;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_pin (rx_pin),
    .rx_s   (rx_s),
    .fall   (fall)
  );

  assign edge_ok = fall && (ign_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cycle_cnt <= 16'd0;
      ign_cnt   <= 16'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      cycle_cnt <= cycle_cnt + 16'd1;
      if (ign_cnt != 16'd0)
        ign_cnt <= ign_cnt - 16'd1;
      unique case (state)
        S_IDLE: begin
          if (edge_ok) begin
            state     <= S_START;
            cycle_cnt <= 16'd0;
            bit_cnt   <= 3'd0;
          end
        end
        S_START: begin
          if (cycle_cnt == MID_C && rx_s) begin
            state     <= S_IDLE;
            cycle_cnt <= 16'd0;
          end else if (cycle_cnt == END_C) begin
            state     <= S_REC_BYTE;
            cycle_cnt <= 16'd0;
          end
        end
        S_REC_BYTE: begin
          if (cycle_cnt == MID_C)
            shift_reg[bit_cnt] <= rx_s;
          if (cycle_cnt == END_C) begin
            cycle_cnt <= 16'd0;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= S_STOP;
          end
        end
        S_STOP: begin
          if (cycle_cnt == MID_C) begin
            cycle_cnt <= 16'd0;
            if (rx_s) begin
              data_q  <= shift_reg;
              valid_q <= 1'b1;
              state   <= S_DATA;
            end else begin
              fe_q  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (bus.rx_data_ready) begin
            valid_q   <= 1'b0;
            state     <= S_IDLE;
            cycle_cnt <= 16'd0;
          end
          if (edge_ok) begin
            ov_q    <= 1'b1;
            ign_cnt <= IGN_C;
          end
        end
        default: begin
          state     <= S_IDLE;
          cycle_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign bus.rx_data       = data_q;
  assign bus.rx_data_valid = valid_q;
  assign bus.frame_err     = fe_q;
  assign bus.overrun_err   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx at CYCLE=10.
// Main process drives frames; a monitor checks bytes and pulses.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CYC = cycle_of(1, 100000);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_pin = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FRE   (1),
    .BAUD_RATE (100000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_pin (rx_pin),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  int act_fe = 0;
  int act_ov = 0;
  logic [7:0] q[$];
  bit held = 1'b0;
  bit prev_acc = 1'b0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(bit r);
    bus.rx_data_ready = r;
    if (r) held = 1'b0;
  endtask

  // Reference: decide the fate of a frame at its start edge.
  task automatic model_frame(logic [7:0] b, bit stop_ok);
    if (held)
      exp_ov++;
    else if (!stop_ok)
      exp_fe++;
    else begin
      q.push_back(b);
      if (!bus.rx_data_ready) held = 1'b1;
    end
  endtask

  task automatic send(logic [7:0] b, bit stop_ok);
    model_frame(b, stop_ok);
    rx_pin = 1'b0;
    tick(CYC);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(CYC);
    end
    rx_pin = stop_ok;
    tick(CYC);
    rx_pin = 1'b1;
    if (!stop_ok) tick(3);
  endtask

  task automatic drain(string name);
    int n = 0;
    while (q.size() != 0 && n < 6 * CYC) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, q.size(), 0);
    q.delete();
    check({name, "_frame_err"}, act_fe, exp_fe);
    check({name, "_overrun"}, act_ov, exp_ov);
  endtask

  task automatic check_idle_outputs(string name);
    @(negedge clk);
    check({name, "_data"}, int'(bus.rx_data), 0);
    check({name, "_valid"}, int'(bus.rx_data_valid), 0);
    check({name, "_fe"}, int'(bus.frame_err), 0);
    check({name, "_ov"}, int'(bus.overrun_err), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_acc = 1'b0;
    end else begin
      if (bus.frame_err) act_fe++;
      if (bus.overrun_err) act_ov++;
      if (prev_acc) begin
        checks++;
        if (bus.rx_data_valid) begin
          failures++;
          $display("FAIL valid_width valid=1 after accept exp=0");
        end
      end
      prev_acc = bus.rx_data_valid && bus.rx_data_ready;
      if (bus.rx_data_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid data=%h", bus.rx_data);
        end else if (bus.rx_data !== q[0]) begin
          failures++;
          $display("FAIL rx_data got=%h exp=%h",
                   bus.rx_data, q[0]);
        end
        if (bus.rx_data_ready && q.size() != 0)
          void'(q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit ok;
    int gap;
    bus.rx_data_ready = 1'b1;
    rx_pin = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(5);

    send(8'h55, 1'b1);
    tick(2 * CYC);
    drain("b55");

    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    tick(2 * CYC);
    drain("loop");

    rx_pin = 1'b0;
    tick(3);
    rx_pin = 1'b1;
    tick(2 * CYC);
    check("glitch_pending", q.size(), 0);
    send(8'h81, 1'b1);
    tick(2 * CYC);
    drain("glitch");

    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    tick(2 * CYC);
    drain("stop_low");

    set_ready(1'b0);
    send(8'h11, 1'b1);
    tick(5);
    send(8'h22, 1'b1);
    tick(2 * CYC);
    @(negedge clk);
    check("held_valid", int'(bus.rx_data_valid), 1);
    check("held_data", int'(bus.rx_data), 8'h11);
    check("held_ov", act_ov, exp_ov);
    @(posedge clk);
    #1 set_ready(1'b1);
    tick(2 * CYC);
    drain("overrun");

    rx_pin = 1'b0;
    tick(30 * CYC);
    exp_fe++;
    rx_pin = 1'b1;
    tick(2 * CYC);
    drain("break");

    b = 8'hC3;
    rx_pin = 1'b0;
    tick(CYC);
    for (int i = 0; i < 4; i++) begin
      rx_pin = b[i];
      tick(CYC);
    end
    rst_n = 1'b0;
    check_idle_outputs("midreset");
    rx_pin = 1'b1;
    tick(2 * CYC);
    rst_n = 1'b1;
    tick(2 * CYC);
    send(8'h7E, 1'b1);
    tick(2 * CYC);
    drain("after_reset");

    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 12);
      send(b, ok);
      if (gap > 0) tick(gap);
    end
    tick(2 * CYC);
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
